// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package riscv_muldiv_pkg;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;
  localparam logic [2:0] DIV_F3    = 3'b100;
  localparam logic [2:0] DIVU_F3   = 3'b101;
  localparam logic [2:0] REM_F3    = 3'b110;
  localparam logic [2:0] REMU_F3   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_t;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add / restoring divide over
// DATA_W steps, followed by one sign-fixup cycle. Divide-by-zero and overflow bypass CALC.
module riscv_muldiv_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              kill,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  done_tag
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  md_state_t           r_state;
  logic [2:0]          r_f3;
  logic [TAG_W-1:0]    r_tag;
  logic                r_neg;
  logic [DATA_W-1:0]   r_opnd;
  logic [2*DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_result;
  logic [TAG_W-1:0]    r_done_tag;

  // Operand decode at accept time.
  logic              w_a_sgn, w_b_sgn, w_neg, w_div0, w_ovf;
  logic [DATA_W-1:0] w_mag_a, w_mag_b, w_fast_res;

  assign w_a_sgn = op_a[DATA_W-1] &
                   (funct3 inside {MUL_F3, MULH_F3, MULHSU_F3, DIV_F3, REM_F3});
  assign w_b_sgn = op_b[DATA_W-1] & (funct3 inside {MUL_F3, MULH_F3, DIV_F3, REM_F3});
  assign w_mag_a = w_a_sgn ? -op_a : op_a;
  assign w_mag_b = w_b_sgn ? -op_b : op_b;
  assign w_neg   = (funct3 == REM_F3) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
  assign w_div0  = is_div(funct3) && (op_b == '0);
  assign w_ovf   = (funct3 inside {DIV_F3, REM_F3}) && (op_a == MIN_NEG) && (op_b == '1);
  assign w_fast_res = w_div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);

  // Shared adder/subtractor: adds the multiplicand or subtracts the divisor.
  logic                w_div;
  logic [DATA_W+1:0]   w_add_a, w_add_b, w_sum;
  logic [2*DATA_W-1:0] w_step;

  assign w_div   = is_div(r_f3);
  assign w_add_a = w_div ? {1'b0, r_acc[2*DATA_W-1:DATA_W-1]} : {2'b00, r_acc[2*DATA_W-1:DATA_W]};
  assign w_add_b = {2'b00, (w_div || r_acc[0]) ? r_opnd : {DATA_W{1'b0}}};
  assign w_sum   = w_add_a + (w_add_b ^ {(DATA_W+2){w_div}}) + {{(DATA_W+1){1'b0}}, w_div};

  always_comb begin
    w_step = {w_sum[DATA_W:0], r_acc[DATA_W-1:1]};
    if (w_div) begin
      if (w_sum[DATA_W+1]) w_step = {r_acc[2*DATA_W-2:0], 1'b0};
      else                 w_step = {w_sum[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
    end
  end

  // Sign fixup: quotient in the low half, remainder in the high half after division.
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_dv, w_dv_s, w_fix_res;

  assign w_prod    = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_dv      = r_f3[1] ? r_acc[2*DATA_W-1:DATA_W] : r_acc[DATA_W-1:0];
  assign w_dv_s    = r_neg ? -w_dv : w_dv;
  assign w_fix_res = w_div ? w_dv_s :
                     (r_f3 == MUL_F3) ? w_prod[DATA_W-1:0] : w_prod[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_f3       <= '0;
      r_tag      <= '0;
      r_neg      <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_done_tag <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (start && !kill) begin
            r_f3   <= funct3;
            r_tag  <= rd_tag;
            r_neg  <= w_neg;
            r_opnd <= is_div(funct3) ? w_mag_b : w_mag_a;
            r_acc  <= {{DATA_W{1'b0}}, is_div(funct3) ? w_mag_a : w_mag_b};
            r_cnt  <= '0;
            if (w_div0 || w_ovf) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_result   <= w_fast_res;
              r_done_tag <= rd_tag;
            end else begin
              r_state <= CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (kill) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(DATA_W - 1)) r_state <= FIX;
          end
        end
        FIX: begin
          r_state <= kill ? IDLE : DONE;
          r_busy  <= 1'b0;
          if (!kill) begin
            r_done     <= 1'b1;
            r_result   <= w_fix_res;
            r_done_tag <= r_tag;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign done_tag = r_done_tag;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed and randomized checks of riscv_muldiv_unit against an arithmetic reference model.
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_tag;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  done_tag;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;

  riscv_muldiv_unit #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_tag(rd_tag), .busy(busy), .done(done),
    .result(result), .done_tag(done_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: plain 64-bit arithmetic from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, b, input logic [4:0] tag);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_tag = tag; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; rd_tag = 5'($urandom);
  endtask

  // Waits for done (sample 1 = first cycle after the accept edge); optionally pokes start mid-op.
  task automatic finish(input string tag, input logic [31:0] exp, input logic [4:0] etag,
                        input int elat, input int inject_at);
    int lat;
    lat = 1;
    while (!done && lat < 60) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      if (lat == inject_at) begin
        start = 1'b1; funct3 = 3'd0; op_a = 32'd1; op_b = 32'd1; rd_tag = ~etag;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " result"}, result, exp);
    chk({tag, " tag"}, {27'd0, done_tag}, {27'd0, etag});
    chk({tag, " busy@done"}, {31'd0, busy}, 32'd0);
    last_res = exp;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, b,
                       input logic [4:0] t, input logic [31:0] exp);
    issue(f, a, b, t);
    finish(tag, exp, t, exp_latency(f, a, b), 0);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    chk({tag, " done-pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " held"}, result, last_res);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  t;

    reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset tag", {27'd0, done_tag}, 32'd0);
    reset = 1'b0;
    last_res = 32'd0;

    // Consecutive do_op calls issue in the DONE cycle, so these are back-to-back starts.
    do_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    do_op("mulh", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000);
    do_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000);
    do_op("mulhu", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h7FFF_FFFF);
    do_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    do_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    do_op("divu 100/7", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14);
    do_op("remu 100/7", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2);
    do_op("divu 5/0", 3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
    do_op("rem 5/0", 3'd6, 32'd5, 32'd0, 5'd10, 32'd5);
    do_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    do_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);
    idle_check("after fast");

    // Kill in the tenth busy cycle: no done, busy drops, result untouched.
    issue(3'd4, 32'd1000, 32'd3, 5'd13);
    repeat (9) begin
      @(posedge clk); #1;
      chk("kill no-done", {31'd0, done}, 32'd0);
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill busy", {31'd0, busy}, 32'd0);
    chk("kill done", {31'd0, done}, 32'd0);
    chk("kill held", result, last_res);
    do_op("mul 3*4 after kill", 3'd0, 32'd3, 32'd4, 5'd14, 32'd12);

    // Kill together with start in idle: start is dropped.
    idle_check("pre kill+start");
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    chk("kill+start busy", {31'd0, busy}, 32'd0);
    chk("kill+start done", {31'd0, done}, 32'd0);

    // A second start while busy must be ignored.
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15);
    finish("start-while-busy", model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), 5'd15, 34, 5);
    idle_check("after ignored start");

    // Reset mid-operation.
    issue(3'd5, 32'hDEAD_BEEF, 32'd77, 5'd16);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset result", result, 32'd0);
    chk("midreset tag", {27'd0, done_tag}, 32'd0);
    last_res = 32'd0;
    repeat (40) begin
      @(posedge clk); #1;
      chk("midreset no-done", {31'd0, done}, 32'd0);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = pick();
      b = pick();
      t = 5'($urandom);
      do_op($sformatf("rand%0d f3=%0d a=%h b=%h", i, f, a, b), f, a, b, t, model(f, a, b));
      if ($urandom % 2 == 0) idle_check("rand gap");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit, parametrised in operand width, for the next-generation core datapath.
- Accepts one M-extension operation at a time through a start/busy/done handshake.
- Computes it over multiple cycles while the core stalls.
- Returns the result with its destination-register tag for writeback.
- Sits beside the ALU in the execute stage; the controller raises `start` on opcode 0110011 with funct7 = 0000001.

Parameters:
- DATA_W, 32: operand/result width; even, >= 8.
- TAG_W, 5: destination-register tag width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- kill  input  1  flush; aborts the in-flight operation.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  DATA_W  rs1 value.
- op_b  input  DATA_W  rs2 value.
- rd_tag  input  TAG_W  destination register number.
- busy  output  1  unit occupied; the core stalls while high.
- done  output  1  one-cycle pulse; result is valid.
- result  output  DATA_W  operation result; held until the next accepted start.
- done_tag  output  TAG_W  rd_tag of the completed operation.

Behaviour:
- Reset (synchronous, active-high, from any state):
  - State returns to IDLE.
  - busy=0, done=0, result=0, done_tag=0.
  - All internal accumulators cleared.
- States: IDLE, CALC, FIX, DONE.
- Accept: start=1 in IDLE at edge t latches funct3, rd_tag, the operand magnitudes and the result sign. start while busy=1 is ignored.
- Normal path:
  - CALC occupies edges t+1 .. t+DATA_W: one shift-add (mul) or restoring-subtract (div) step per cycle on a 2*DATA_W accumulator.
  - FIX at t+DATA_W+1: two's-complement sign correction.
  - DONE at t+DATA_W+2: done=1 for exactly one cycle, then IDLE.
  - Total latency DATA_W+2 cycles.
- busy is 1 in CALC and FIX and 0 in IDLE and DONE, so a new start can be accepted in the DONE cycle.
- Fast path: IDLE goes directly to DONE, with done at t+1, for:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = op_a.
  - Signed overflow, DIV with op_a = -2^(DATA_W-1) and op_b = -1: quotient = op_a, REM = 0.
- Operand signedness:
  - MUL: low DATA_W bits of the product.
  - MULH: signed×signed, high half.
  - MULHSU: signed op_a × unsigned op_b, high half.
  - MULHU: unsigned×unsigned, high half.
- Division signs: quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend (truncating division).
- kill=1 while busy=1: next state IDLE; no done pulse; result and done_tag keep their previous values.
- Simultaneous events:
  - kill together with start in IDLE: start is ignored.
  - reset has priority over kill and start.
- Operand inputs are don't-care after acceptance; the unit uses only latched copies.

Decomposition:
- Package riscv_muldiv_pkg holds:
  - funct3 localparams MUL_F3 .. REMU_F3.
  - typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_t.
  - Helper function is_div(funct3).
- No sub-module: the single FSM plus a shared DATA_W-bit adder/subtractor fits in one module.
- A 2*DATA_W counter-free step uses a log2(DATA_W)+1-bit iteration counter.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), rd_tag=5 → done at cycle t+34, result 0xFFFFFFEB, done_tag 5; busy high cycles t+1..t+33.
- MULH / MULHSU / MULHU with 0x80000000 × 0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 5 / 0 → done at t+1, result 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / -1 → done at t+1, result 0x80000000.
- Start DIV at t, kill at t+10 → no done pulse, busy low at t+11; a new MUL 3×4 started at t+11 returns 12 at t+45.
- Start while busy (second start at t+5) ignored; reset at t+20 → busy=0, result=0 next cycle; back-to-back start in the DONE cycle accepted.
